unidade_controle_multiciclo: RTL

//  Moore FSM that sequences the multicycle MIPS datapath: PC, memory, IR, register file and ALU.

---
 rtl/controle_pkg.sv | 67 ++++++
 rtl/contador_espera.sv | 36 +++
 rtl/unidade_controle_multiciclo.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/controle_pkg.sv
// Shared types and constants for the multicycle MIPS control unit: state encoding, opcodes,
// ALU-op codes, mux selects and the control word driven by the FSM.
package controle_pkg;

    typedef enum logic [3:0] {
        RESET   = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEM_ADR = 4'd3,
        MEM_RD  = 4'd4,
        MEM_WB  = 4'd5,
        MEM_WR  = 4'd6,
        EXEC_R  = 4'd7,
        WB_R    = 4'd8,
        EXEC_I  = 4'd9,
        WB_I    = 4'd10,
        BRANCH  = 4'd11,
        JUMP    = 4'd12
    } estado_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_c;
        logic       br_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    // States that hold a memory read open for MEM_WAIT cycles.
    function automatic logic eh_leitura(input estado_t e);
        return (e == FETCH) || (e == MEM_RD);
    endfunction

endpackage

// File: rtl/contador_espera.sv
// Memory-wait counter shared by FETCH and MEM_RD: counts while enabled and flags the last
// wait cycle, wrapping to zero on that cycle.
module contador_espera
    import controle_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic conta_i,
    output logic ultimo_o
);

    localparam logic [3:0] ULTIMO = 4'(MEM_WAIT - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign ultimo_o = conta_i && (cnt_q == ULTIMO);

    always_comb begin
        cnt_d = '0;
        if (conta_i && !ultimo_o) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Moore control FSM for the multicycle MIPS datapath (R-type, LW, SW, BEQ, BNE, J, ADDI),
// with memory-read states stretched by a MEM_WAIT-cycle counter.
module unidade_controle_multiciclo
    import controle_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_write_c,
    output logic       br_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] estado
);

    if (MEM_WAIT < 1 || MEM_WAIT > 15) begin : g_mem_wait_range
        $error("MEM_WAIT must be in 1..15");
    end

    estado_t estado_q;
    estado_t estado_d;
    logic    br_ne_q;
    logic    br_ne_d;
    logic    ultimo;
    ctrl_t   ctrl;

    // The datapath gates the conditional PC load with zero; the FSM never looks at it.
    logic unused_zero;
    assign unused_zero = zero;

    contador_espera #(
        .MEM_WAIT(MEM_WAIT)
    ) u_contador_espera (
        .clk     (clk),
        .reset   (reset),
        .conta_i (eh_leitura(estado_q)),
        .ultimo_o(ultimo)
    );

    always_comb begin
        estado_d = estado_q;
        br_ne_d  = br_ne_q;
        ctrl     = '0;
        unique case (estado_q)
            RESET: begin
                estado_d = FETCH;
            end
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                if (ultimo) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    estado_d      = DECODE;
                end
            end
            DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
                // Latch the branch sense here so BRANCH itself does not read opcode.
                br_ne_d        = (opcode == OP_BNE);
                case (opcode)
                    OP_R:           estado_d = EXEC_R;
                    OP_LW, OP_SW:   estado_d = MEM_ADR;
                    OP_BEQ, OP_BNE: estado_d = BRANCH;
                    OP_J:           estado_d = JUMP;
                    OP_ADDI:        estado_d = EXEC_I;
                    default: begin
                        ctrl.illegal_op = 1'b1;
                        estado_d        = FETCH;
                    end
                endcase
            end
            MEM_ADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                estado_d       = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (ultimo) begin
                    ctrl.mdr_write = 1'b1;
                    estado_d       = MEM_WB;
                end
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                estado_d        = FETCH;
            end
            MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                estado_d       = FETCH;
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
                estado_d       = WB_R;
            end
            WB_R: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                estado_d        = FETCH;
            end
            EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                estado_d       = WB_I;
            end
            WB_I: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                estado_d        = FETCH;
            end
            BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_B;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_source  = PCSRC_ALUOUT;
                ctrl.pc_write_c = 1'b1;
                ctrl.br_ne      = br_ne_q;
                estado_d        = FETCH;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                estado_d       = FETCH;
            end
            default: begin
                estado_d = RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= RESET;
            br_ne_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            br_ne_q  <= br_ne_d;
        end
    end

    assign pc_write   = ctrl.pc_write;
    assign pc_write_c = ctrl.pc_write_c;
    assign br_ne      = ctrl.br_ne;
    assign i_or_d     = ctrl.i_or_d;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign mdr_write  = ctrl.mdr_write;
    assign reg_dst    = ctrl.reg_dst;
    assign reg_write  = ctrl.reg_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_source  = ctrl.pc_source;
    assign illegal_op = ctrl.illegal_op;
    assign estado     = estado_q;

    a_mem_excl: assert property (@(posedge clk) disable iff (reset) !(mem_read && mem_write));
    a_no_wb_early: assert property (@(posedge clk) disable iff (reset)
        !(((estado_q == FETCH) || (estado_q == DECODE)) && reg_write));

endmodule
